// File: rtl/popcount_pkg.sv
// Shared constants for the round-robin popcount scheduler.
// Default word/count widths and the width of the completed-word counter.
package popcount_pkg;

   localparam int POPCNT_W     = 7;
   localparam int POPCNT_CW    = 3;
   localparam int WORDS_DONE_W = 16;

endpackage

// File: rtl/popcount_unit.sv
// Combinational ones-counter: zero-extended sum of the W input bits.
module popcount_unit
   import popcount_pkg::*;
#(
   parameter int W  = POPCNT_W,
   parameter int CW = POPCNT_CW
) (
   input  logic [W-1:0]  word,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(word[i]);
      end
   end

endmodule

// File: rtl/popcount_rr_sched.sv
// Round-robin scheduler sharing one popcount datapath among NREQ requesters,
// with a single backpressured result register and a wrapping completion counter.
module popcount_rr_sched
   import popcount_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = POPCNT_W,
   parameter int CW   = $clog2(W + 1),
   parameter int IW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*W-1:0]       req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [CW-1:0]           res_count,
   output logic [IW-1:0]           res_id,
   output logic [WORDS_DONE_W-1:0] words_done
);

   logic [W-1:0]            words [NREQ];
   logic [2*NREQ-1:0]       valid_dbl;
   logic [2*NREQ-1:0]       valid_rot;
   logic [IW-1:0]           grant_offset;
   logic [IW:0]             grant_sum;
   logic                    grant_found;
   logic                    accept;
   logic                    grant;
   logic [IW-1:0]           grant_idx;
   logic [IW-1:0]           ptr_next;
   logic [W-1:0]            word_sel;
   logic [CW-1:0]           count_next;

   logic                    res_valid_reg;
   logic [CW-1:0]           res_count_reg;
   logic [IW-1:0]           res_id_reg;
   logic [IW-1:0]           ptr_reg;
   logic [WORDS_DONE_W-1:0] words_done_reg;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign words[gi]     = req_data[gi*W +: W];
         assign req_ready[gi] = grant && (grant_idx == IW'(gi));
      end
   endgenerate

   assign accept = !res_valid_reg || res_ready;

   // Rotate the request vector so bit 0 is the requester at ptr; the lowest
   // set bit is then the first candidate in round-robin order.
   assign valid_dbl = {req_valid, req_valid};
   assign valid_rot = valid_dbl >> ptr_reg;

   always_comb begin
      grant_found  = 1'b0;
      grant_offset = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (valid_rot[k]) begin
            grant_found  = 1'b1;
            grant_offset = IW'(k);
         end
      end
   end

   always_comb begin
      grant_sum = {1'b0, ptr_reg} + {1'b0, grant_offset};
      if (grant_sum >= (IW+1)'(NREQ)) begin
         grant_sum = grant_sum - (IW+1)'(NREQ);
      end
   end

   assign grant_idx = grant_sum[IW-1:0];
   assign grant     = accept && grant_found && !rst;
   assign ptr_next  = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
   assign word_sel  = words[grant_idx];

   popcount_unit #(
      .W  (W),
      .CW (CW)
   ) u_popcount (
      .word  (word_sel),
      .count (count_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_reg  <= 1'b0;
         res_count_reg  <= '0;
         res_id_reg     <= '0;
         ptr_reg        <= '0;
         words_done_reg <= '0;
      end else begin
         if (grant) begin
            res_valid_reg <= 1'b1;
            res_count_reg <= count_next;
            res_id_reg    <= grant_idx;
            ptr_reg       <= ptr_next;
         end else if (res_ready) begin
            res_valid_reg <= 1'b0;
         end
         if (res_valid_reg && res_ready) begin
            words_done_reg <= words_done_reg + WORDS_DONE_W'(1);
         end
      end
   end

   assign res_valid  = res_valid_reg;
   assign res_count  = res_count_reg;
   assign res_id     = res_id_reg;
   assign words_done = words_done_reg;

endmodule

// File: tb/tb_popcount_rr_sched.sv
// Directed bench for popcount_rr_sched: a cycle model checks every output each
// cycle, and literal expectations pin the model at key points.
module tb_popcount_rr_sched;

   localparam int NREQ = 4;
   localparam int W    = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [27:0] req_data  = '0;
   logic        res_ready = 1'b0;
   wire  [3:0]  req_ready;
   wire         res_valid;
   wire  [2:0]  res_count;
   wire  [1:0]  res_id;
   wire  [15:0] words_done;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   always #5 clk = ~clk;

   popcount_rr_sched dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_count  (res_count),
      .res_id     (res_id),
      .words_done (words_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: state of the result register and the rotation pointer.
   logic        m_valid = 1'b0;
   logic [2:0]  m_count = '0;
   logic [1:0]  m_id    = '0;
   int          m_ptr   = 0;
   logic [15:0] m_done  = '0;
   logic        n_valid;
   logic [2:0]  n_count;
   logic [1:0]  n_id;
   int          n_ptr;
   logic [15:0] n_done;
   int          g_exp;
   logic [31:0] ready_exp;

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_res_valid", res_valid, m_valid);
         check("model_res_count", res_count, m_count);
         check("model_res_id", res_id, m_id);
         check("model_words_done", words_done, m_done);
         g_exp = -1;
         if (!rst && (!m_valid || res_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
               if (g_exp < 0 && req_valid[(m_ptr + k) % NREQ]) g_exp = (m_ptr + k) % NREQ;
            end
         end
         ready_exp = (g_exp >= 0) ? (32'd1 << g_exp) : 32'd0;
         check("model_req_ready", req_ready, ready_exp);
         if (rst) begin
            n_valid = 1'b0; n_count = '0; n_id = '0; n_ptr = 0; n_done = '0;
         end else begin
            n_done  = m_done + ((m_valid && res_ready) ? 16'd1 : 16'd0);
            n_valid = m_valid; n_count = m_count; n_id = m_id; n_ptr = m_ptr;
            if (g_exp >= 0) begin
               n_valid = 1'b1;
               n_count = 3'($countones(req_data[g_exp*W +: W]));
               n_id    = 2'(g_exp);
               n_ptr   = (g_exp + 1) % NREQ;
            end else if (res_ready) begin
               n_valid = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (chk_en) begin
         m_valid <= n_valid;
         m_count <= n_count;
         m_id    <= n_id;
         m_ptr   <= n_ptr;
         m_done  <= n_done;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int i, input logic [6:0] w);
      req_data[i*W +: W] = w;
   endtask

   task automatic do_reset();
      step();
      rst       = 1'b1;
      req_valid = '0;
      res_ready = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "time limit expired");
   end

   int          rr_id  [5] = '{0, 1, 2, 3, 0};
   int          rr_cnt [5] = '{7, 0, 2, 1, 7};
   logic [6:0]  sr_word[5] = '{7'b0000001, 7'b0101001, 7'b0111101, 7'b1110101, 7'b0010101};
   int          sr_cnt [5] = '{1, 3, 5, 5, 3};

   initial begin
      // Reset with every requester valid
      rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b1;
      set_word(0, 7'b1111111); set_word(1, 7'b0000000);
      set_word(2, 7'b0000011); set_word(3, 7'b1000000);
      step();
      chk_en = 1'b1;
      #2;
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_count", res_count, 3'd0);
      check("rst_res_id", res_id, 2'd0);
      check("rst_words_done", words_done, 16'd0);
      step();
      rst = 1'b0;
      #2;
      check("first_grant", req_ready, 4'b0001);
      for (int i = 0; i < 5; i++) begin
         step();
         #2;
         check("rr_valid", res_valid, 1'b1);
         check("rr_id", res_id, rr_id[i]);
         check("rr_count", res_count, rr_cnt[i]);
      end

      // Single requester 2
      do_reset();
      req_valid = 4'b0100;
      set_word(2, sr_word[0]);
      #2;
      check("single_ready", req_ready, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         step();
         if (i < 4) set_word(2, sr_word[i+1]);
         else req_valid = 4'b0000;
         #2;
         check("single_count", res_count, sr_cnt[i]);
         check("single_id", res_id, 2'd2);
      end
      step();
      #2;
      check("single_drain_valid", res_valid, 1'b0);
      check("single_words_done", words_done, 16'd5);

      // Backpressure
      do_reset();
      req_valid = 4'b0011;
      set_word(0, 7'b0000111); set_word(1, 7'b0001111);
      #2;
      check("bp_first_ready", req_ready, 4'b0001);
      step();
      set_word(0, 7'b0000001);
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         #2;
         check("bp_ready", req_ready, 4'b0000);
         check("bp_valid", res_valid, 1'b1);
         check("bp_id", res_id, 2'd0);
         check("bp_count", res_count, 3'd3);
         check("bp_words_done", words_done, 16'd0);
      end
      res_ready = 1'b1;
      #1;
      check("bp_release_ready", req_ready, 4'b0010);
      step();
      #2;
      check("bp_next_id", res_id, 2'd1);
      check("bp_next_count", res_count, 3'd4);
      check("bp_next_words_done", words_done, 16'd1);
      check("bp_next_ready", req_ready, 4'b0001);
      step();
      req_valid = 4'b0000;
      #2;
      check("bp_last_id", res_id, 2'd0);
      check("bp_last_count", res_count, 3'd1);
      check("bp_last_words_done", words_done, 16'd2);

      // Fairness after a gap
      do_reset();
      req_valid = 4'b1000;
      set_word(3, 7'b1010101);
      #2;
      check("fair_ready_3", req_ready, 4'b1000);
      step();
      req_valid = 4'b1001;
      set_word(0, 7'b1100000); set_word(3, 7'b0000000);
      #2;
      check("fair_id_3", res_id, 2'd3);
      check("fair_count_3", res_count, 3'd4);
      check("fair_ready_0", req_ready, 4'b0001);
      step();
      set_word(0, 7'b0000001);
      #2;
      check("fair_id_0", res_id, 2'd0);
      check("fair_count_0", res_count, 3'd2);
      check("fair_ready_3b", req_ready, 4'b1000);
      step();
      req_valid = 4'b0000;
      #2;
      check("fair_id_3b", res_id, 2'd3);
      check("fair_count_3b", res_count, 3'd0);

      // Counter wrap followed by a reset with a result in flight
      do_reset();
      req_valid = 4'b0001;
      set_word(0, 7'b0110110);
      repeat (65538) step();
      #2;
      check("wrap_words_done", words_done, 16'h0001);
      check("wrap_res_valid", res_valid, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 4'b0000;
      #2;
      check("midrst_res_valid", res_valid, 1'b0);
      check("midrst_words_done", words_done, 16'd0);
      check("midrst_res_count", res_count, 3'd0);
      step();
      #2;
      check("midrst_words_done_hold", words_done, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
